// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

  // Execute operand source select, encoded as the mux select the datapath uses.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Multi-cycle sequencer states.
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // ResultSrcE encoding that marks a load in Execute.
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Operand forwarding for one source register; Memory wins over Writeback
  // because it holds the younger producer. x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic       i_reg_write_m,
    input logic [4:0] i_rd_m,
    input logic       i_reg_write_w,
    input logic [4:0] i_rd_w,
    input logic [4:0] i_rs
  );
    fwd_sel_t w_sel;
    w_sel = FWD_RF;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs)) begin
      w_sel = FWD_M;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs)) begin
      w_sel = FWD_W;
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline-status inputs and hazard-control outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; stalls are carried as plain level signals.
interface hazard_controller_if #(
  parameter int CNT_W = 32
) ();

  // Register addresses of in-flight instructions
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  // Stage control status
  logic             RegWriteM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             MultiCycleE;
  // Hazard responses
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             McBusy;
  logic             McDoneE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  // Controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, McBusy, McDoneE, StallCount, FlushCount
  );

  // Pipeline side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, McBusy, McDoneE, StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_controller_mc_sequencer.sv
// Holds Execute for MC_LATENCY cycles while a multi-cycle ALU op runs.
// Latency: o_mc_stall combinational from state/input; op completes after MC_LATENCY cycles.
// Backpressure: asserts o_mc_stall for MC_LATENCY-1 cycles; new requests ignored while busy.
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_multi_cycle,
  output logic o_mc_stall,
  output logic o_mc_busy,
  output logic o_mc_done
);

  // Counter only needs to hold MC_LATENCY-2 (at most 14).
  localparam int            CW       = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 2);

  mc_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // State and down-counter: the IDLE cycle that accepts the op is cycle 1,
  // so BUSY lasts MC_LATENCY-1 cycles and ends on the cnt==0 cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= MC_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MC_IDLE: begin
          if (i_multi_cycle) begin
            r_state <= MC_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        MC_BUSY: begin
          if (w_cnt_zero) begin
            r_state <= MC_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= MC_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Stall while the op is still computing; release on its final cycle.
  always_comb begin
    o_mc_stall = 1'b0;
    o_mc_busy  = 1'b0;
    o_mc_done  = 1'b0;
    if (r_state == MC_IDLE) begin
      o_mc_stall = i_multi_cycle;
    end else begin
      o_mc_busy  = 1'b1;
      o_mc_stall = !w_cnt_zero;
      o_mc_done  = w_cnt_zero;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding, load-use stall, branch flush and multi-cycle hold for the 5-stage core.
// Latency: all control outputs combinational in the same cycle; counters update on the edge.
// Backpressure: stalls F/D (and E for multi-cycle ops); bubbles inserted via flushes.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  hazard_controller_if.slave  hz
);

  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;
  logic             w_lw_stall;
  logic             w_mc_stall;
  logic             w_mc_busy;
  logic             w_mc_done;
  logic             w_stall_f;
  logic             w_flush_e;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  mc_sequencer #(
    .MC_LATENCY (MC_LATENCY)
  ) u_mc_sequencer (
    .CLK           (CLK),
    .RESET         (RESET),
    .i_multi_cycle (hz.MultiCycleE),
    .o_mc_stall    (w_mc_stall),
    .o_mc_busy     (w_mc_busy),
    .o_mc_done     (w_mc_done)
  );

  // Operand forwarding selects for Execute.
  always_comb begin
    w_fwd_a = fwd_select(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
    w_fwd_b = fwd_select(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);
  end

  // Load in Execute whose destination is read by Decode: one-cycle bubble.
  always_comb begin
    w_lw_stall = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                 ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end

  // Merge hazard sources; a running multi-cycle op must never be flushed.
  always_comb begin
    w_stall_f = w_lw_stall | w_mc_stall;
    w_flush_e = (w_lw_stall | hz.PCSrcE) & ~w_mc_stall;
  end

  assign hz.ForwardAE  = w_fwd_a;
  assign hz.ForwardBE  = w_fwd_b;
  assign hz.StallF     = w_stall_f;
  assign hz.StallD     = w_stall_f;
  assign hz.StallE     = w_mc_stall;
  assign hz.FlushD     = hz.PCSrcE & ~w_mc_stall;
  assign hz.FlushE     = w_flush_e;
  assign hz.FlushM     = w_mc_stall;
  assign hz.McBusy     = w_mc_busy;
  assign hz.McDoneE    = w_mc_done;
  assign hz.StallCount = r_stall_count;
  assign hz.FlushCount = r_flush_count;

  // Saturating performance counters for stall and Execute-flush cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_f && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush_e && !(&r_flush_count)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the five-stage core. It generates the Execute-stage operand forwarding selects and the load-use stall. It also generates the flushes for taken branches and jumps. It runs a small sequencer that holds the Fetch, Decode and Execute stages while a multi-cycle ALU operation occupies Execute, and bubbles the Memory stage meanwhile. Saturating stall and flush counters are exposed for performance debug.

## Interface
- MC_LATENCY, 4, number of cycles a multi-cycle op occupies Execute; legal range 2..16
- CNT_W, 32, width of the performance counters
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in Execute
- RdM, RdW  in  5  destination registers in Memory and Writeback
- RegWriteM, RegWriteW  in  1  register write enables in Memory and Writeback
- ResultSrcE  in  2  result select in Execute; 2'b01 marks a load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MultiCycleE  in  1  instruction in Execute is a multi-cycle op
- ForwardAE, ForwardBE  out  2  operand A/B select: 00 = register file, 10 = ALUResultM, 01 = ResultW
- StallF, StallD, StallE  out  1  hold the PC, IF/ID register and ID/EX register
- FlushD, FlushE, FlushM  out  1  clear the IF/ID, ID/EX and EX/MEM registers to a bubble
- McBusy  out  1  sequencer is in BUSY
- McDoneE  out  1  final Execute cycle of a multi-cycle op; the ALU result is valid
- StallCount, FlushCount  out  CNT_W  performance counters

## Operation
- **Forwarding** (per operand, combinational):
  - Select 10 if RegWriteM, RdM != 0 and RdM == Rs1E/Rs2E.
  - Otherwise select 01 if RegWriteW, RdW != 0 and RdW == Rs1E/Rs2E.
  - Otherwise select 00. Memory has priority over Writeback.
- **Load-use** (lwStall):
  - Condition: ResultSrcE == 01, RdE != 0, and RdE == Rs1D or RdE == Rs2D.
  - Response: StallF = StallD = 1 and FlushE = 1.
- **Control hazard:** PCSrcE gives FlushD = FlushE = 1.
- **Multi-cycle sequencer**, states IDLE and BUSY, with a down-counter cnt:
  - IDLE and MultiCycleE: mcStall = 1. Next state BUSY, cnt <= MC_LATENCY-2.
  - BUSY with cnt != 0: mcStall = 1, cnt decrements.
  - BUSY with cnt == 0: mcStall = 0 and McDoneE = 1. Next state IDLE.
  - MultiCycleE is ignored while in BUSY.
  - McDoneE = 1 in IDLE when MultiCycleE = 1 and MC_LATENCY... this case cannot occur; MC_LATENCY >= 2.
- **mcStall response:** StallF = StallD = StallE = 1 and FlushM = 1.
- **Priority:**
  - mcStall suppresses FlushE and FlushD, so the multi-cycle op is never killed.
  - PCSrcE and MultiCycleE cannot both be high; the bench never drives that combination.
  - Load-use and mcStall together give the union of stalls, with FlushE suppressed.
- **Counters:**
  - StallCount increments on every cycle with StallF = 1.
  - FlushCount increments on every cycle with FlushE = 1.
  - Both saturate at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state. They are consumed at the same clock edge.
- A multi-cycle op stays in Execute for exactly MC_LATENCY cycles, then advances on the edge after the McDoneE cycle.
- Load-use inserts exactly one bubble. A taken branch costs exactly two cycles.
- **Reset values:** state IDLE, cnt 0, StallCount 0, FlushCount 0. Every combinational output follows from these and the inputs.
- **Reset mid-BUSY:** return to IDLE on the next edge. No McDoneE is produced.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF, FWD_W, FWD_M.
  - mc_state_t enum: MC_IDLE, MC_BUSY.
  - RESULT_SRC_LOAD = 2'b01.
- Sub-module mc_sequencer contains the FSM and cnt. It outputs mcStall, McBusy and McDoneE.
- The top level holds the forwarding logic, load-use detection, output merge and counters.

## Test plan
- **Forwarding:**
  - Stimulus: RegWriteM = 1, RdM = 5, RegWriteW = 1, RdW = 5, Rs1E = 5, Rs2E = 6.
  - Required: ForwardAE = 10, ForwardBE = 00.
  - With RdM = 0 instead, ForwardAE = 01.
- **Load-use:**
  - Stimulus: ResultSrcE = 01, RdE = 7, Rs2D = 7.
  - Required: StallF = StallD = FlushE = 1, StallCount increments by 1.
  - With RdE = 0, no stall.
- **Branch:**
  - Stimulus: PCSrcE = 1 for one cycle.
  - Required: FlushD = FlushE = 1, FlushCount increments by 1, no stalls.
- **Multi-cycle:**
  - Stimulus: MC_LATENCY = 4, MultiCycleE held high.
  - Required: StallE = 1 and FlushM = 1 for 3 cycles. McDoneE = 1 in cycle 4 with stalls low. McBusy is high in cycles 2-4.
- **Reset mid-operation:**
  - Stimulus: RESET in the second BUSY cycle.
  - Required: the next cycle is IDLE, McBusy = 0, both counters 0, no McDoneE.
- **Saturation:**
  - Stimulus: CNT_W = 4, 20 consecutive load-use cycles.
  - Required: StallCount holds at 15.
